// File: rtl/tdo_chain_align_pkg.sv
// Shared types and helpers for the TDO chain aligner.
// Width localparams (REM_W, TOT_W, KW) depend on the instance parameters,
// so they are derived inside each module from DATA_W/LEN_W/CNT_W/STEP.
package tdo_align_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MULT  = 3'd1,
    CALC  = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } align_state_t;

  // Bits to shift this cycle: the remaining distance, capped at the step size.
  function automatic int unsigned min_step(input int unsigned rem, input int unsigned step);
    return (rem < step) ? rem : step;
  endfunction

endpackage

// File: rtl/tdo_chain_align_step_shifter.sv
// Combinational right shift by 0..STEP bits, zero-filling the MSB side.
module tdo_step_shifter #(
  parameter int DATA_W = 4096,
  parameter int STEP   = 8
) (
  input  logic [DATA_W-1:0]          din,
  input  logic [$clog2(STEP+1)-1:0]  k,
  output logic [DATA_W-1:0]          dout
);

  // Logical shift; vacated upper bits become zero.
  always_comb begin
    dout = din >> k;
  end

endmodule

// File: rtl/tdo_chain_align.sv
// Aligns a captured JTAG TDO chain so the valid bits land at [total-1:0].
// Multiplies bit_length by device_count, then walks the capture right by
// up to STEP bits per cycle until DATA_W - total bits have been discarded.
module tdo_chain_align
  import tdo_align_pkg::*;
#(
  parameter int DATA_W     = 4096,
  parameter int LEN_W      = 8,
  parameter int CNT_W      = 5,
  parameter int STEP       = 8,
  parameter int EDGE_START = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    align,
  input  logic [DATA_W-1:0]       JTAG_data_out,
  input  logic [LEN_W-1:0]        bit_length,
  input  logic [CNT_W-1:0]        device_count,
  output logic [DATA_W-1:0]       bits_align,
  output logic [LEN_W+CNT_W-1:0]  total_bits,
  output logic                    align_busy,
  output logic                    align_done,
  output logic                    len_ovf
);

  localparam int REM_W = $clog2(DATA_W + 1);
  localparam int TOT_W = LEN_W + CNT_W;
  localparam int KW    = $clog2(STEP + 1);
  // Common width for comparing/subtracting total against DATA_W without wrap.
  localparam int CW    = ((TOT_W > REM_W) ? TOT_W : REM_W) + 1;

  align_state_t       state_r, state_s;
  logic               start_s;
  logic               align_q_r;
  logic [LEN_W-1:0]   len_l_r;
  logic [CNT_W-1:0]   cnt_l_r;
  logic [REM_W-1:0]   rem_r;
  logic [REM_W-1:0]   rem_calc_s;
  logic               ovf_s;
  logic [KW-1:0]      k_s;
  logic [DATA_W-1:0]  shifted_s;

  tdo_step_shifter #(
    .DATA_W (DATA_W),
    .STEP   (STEP)
  ) u_shifter (
    .din  (bits_align),
    .k    (k_s),
    .dout (shifted_s)
  );

  // Per-cycle shift amount and the overflow/remaining-distance calculation.
  always_comb begin
    k_s        = KW'(min_step(32'(rem_r), 32'(STEP)));
    ovf_s      = (CW'(total_bits) > CW'(DATA_W));
    rem_calc_s = {REM_W{1'b0}};
    if (ovf_s) begin
      rem_calc_s = {REM_W{1'b0}};
    end else begin
      rem_calc_s = REM_W'(CW'(DATA_W) - CW'(total_bits));
    end
  end

  // Start detection and next-state logic.
  always_comb begin
    state_s = state_r;
    if (EDGE_START != 0) begin
      start_s = align & ~align_q_r;
    end else begin
      start_s = align;
    end
    case (state_r)
      IDLE:    state_s = start_s ? MULT : IDLE;
      MULT:    state_s = CALC;
      CALC:    state_s = SHIFT;
      SHIFT:   state_s = (rem_r == {REM_W{1'b0}}) ? DONE : SHIFT;
      DONE:    state_s = start_s ? MULT : IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register, registered status flags and the alignment datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      align_q_r  <= 1'b0;
      len_l_r    <= {LEN_W{1'b0}};
      cnt_l_r    <= {CNT_W{1'b0}};
      rem_r      <= {REM_W{1'b0}};
      bits_align <= {DATA_W{1'b0}};
      total_bits <= {TOT_W{1'b0}};
      align_busy <= 1'b0;
      align_done <= 1'b0;
      len_ovf    <= 1'b0;
    end else begin
      align_q_r  <= align;
      state_r    <= state_s;
      align_busy <= (state_s == MULT) || (state_s == CALC) || (state_s == SHIFT);
      align_done <= (state_s == DONE);
      case (state_r)
        IDLE, DONE: begin
          if (start_s) begin
            bits_align <= JTAG_data_out;
            len_l_r    <= bit_length;
            cnt_l_r    <= device_count;
            len_ovf    <= 1'b0;
          end
        end
        MULT: begin
          total_bits <= TOT_W'(len_l_r) * TOT_W'(cnt_l_r);
        end
        CALC: begin
          len_ovf <= ovf_s;
          rem_r   <= rem_calc_s;
        end
        SHIFT: begin
          if (rem_r != {REM_W{1'b0}}) begin
            bits_align <= shifted_s;
            rem_r      <= rem_r - REM_W'(k_s);
          end
        end
        default: begin
          rem_r <= {REM_W{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tdo_chain_align.sv
// Bench for tdo_chain_align: directed runs with literal expectations plus a
// run-level reference model compared against every output on every cycle.
module tb_tdo_chain_align;

  localparam int DW    = 4096;
  localparam int LW    = 8;
  localparam int CWD   = 5;
  localparam int STP   = 8;
  localparam int BOUND = 700;

  logic              clk;
  logic              rst_n;
  logic              align;
  logic [DW-1:0]     JTAG_data_out;
  logic [LW-1:0]     bit_length;
  logic [CWD-1:0]    device_count;
  logic [DW-1:0]     bits_align;
  logic [LW+CWD-1:0] total_bits;
  logic              align_busy;
  logic              align_done;
  logic              len_ovf;

  int checks;
  int failures;

  tdo_chain_align #(
    .DATA_W(DW), .LEN_W(LW), .CNT_W(CWD), .STEP(STP), .EDGE_START(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .align(align), .JTAG_data_out(JTAG_data_out),
    .bit_length(bit_length), .device_count(device_count), .bits_align(bits_align),
    .total_bits(total_bits), .align_busy(align_busy), .align_done(align_done),
    .len_ovf(len_ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input bit ok, input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s t=%0t got=%h expected=%h", name, $time, got, exp);
    end
  endtask

  // ---------------- reference model (whole-run view) ----------------
  // A run is described by its start edge and its inputs; every output at
  // any later cycle follows from the number of edges since that start.
  function automatic int f_rem(input int t);
    return (t > DW) ? 0 : DW - t;
  endfunction

  function automatic int f_s(input int t);
    return (f_rem(t) + STP - 1) / STP;
  endfunction

  logic [DW-1:0] m_cap;
  int  m_e, m_c0, m_tot, m_prev_tot, m_rem, m_s;
  bit  m_ovf, m_active, m_align_q;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_e <= 0; m_c0 <= 0; m_tot <= 0; m_prev_tot <= 0; m_rem <= 0; m_s <= 0;
      m_ovf <= 1'b0; m_active <= 1'b0; m_align_q <= 1'b0; m_cap <= '0;
    end else begin
      m_e       <= m_e + 1;
      m_align_q <= align;
      if (align && !m_align_q && (!m_active || (m_e - 1 - m_c0) > 2 + m_s)) begin
        m_active   <= 1'b1;
        m_c0       <= m_e;
        m_cap      <= JTAG_data_out;
        m_prev_tot <= m_active ? m_tot : 0;
        m_tot      <= int'(bit_length) * int'(device_count);
        m_ovf      <= (int'(bit_length) * int'(device_count)) > DW;
        m_rem      <= f_rem(int'(bit_length) * int'(device_count));
        m_s        <= f_s(int'(bit_length) * int'(device_count));
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      begin
        int n, sh;
        logic [DW-1:0] eb;
        logic e_busy, e_done, e_ovf;
        int e_tot;
        n = m_e - 1 - m_c0;
        if (!m_active) begin
          eb = '0; e_busy = 1'b0; e_done = 1'b0; e_ovf = 1'b0; e_tot = 0;
        end else begin
          if (n <= 2) begin
            eb = m_cap;
          end else begin
            sh = (n - 2) * STP;
            if (sh > m_rem) sh = m_rem;
            eb = m_cap >> sh;
          end
          e_busy = (n <= 2 + m_s);
          e_done = (n == 3 + m_s);
          e_ovf  = m_ovf && (n >= 2);
          e_tot  = (n >= 1) ? m_tot : m_prev_tot;
        end
        chk(bits_align == eb, "model_bits_align", bits_align[63:0], eb[63:0]);
        chk(align_busy == e_busy, "model_busy", 64'(align_busy), 64'(e_busy));
        chk(align_done == e_done, "model_done", 64'(align_done), 64'(e_done));
        chk(len_ovf == e_ovf, "model_len_ovf", 64'(len_ovf), 64'(e_ovf));
        chk(int'(total_bits) == e_tot, "model_total", 64'(total_bits), 64'(e_tot));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic start_run(input logic [DW-1:0] cap, input int len, input int cnt);
    @(negedge clk);
    JTAG_data_out = cap;
    bit_length    = LW'(len);
    device_count  = CWD'(cnt);
    align         = 1'b1;
  endtask

  // Counts edges until align_done is seen; lat = edges after the first one.
  task automatic wait_done(output int lat);
    lat = -1;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!align_done && lat < BOUND);
    if (!align_done) chk(1'b0, "done_timeout", 64'(lat), 64'(BOUND));
  endtask

  function automatic logic [DW-1:0] rand_cap();
    logic [DW-1:0] c;
    for (int i = 0; i < DW / 32; i++) c[i*32 +: 32] = $urandom;
    return c;
  endfunction

  initial begin
    logic [DW-1:0] cap, exp;
    int lat;
    checks = 0; failures = 0;
    rst_n = 1'b0; align = 1'b0; JTAG_data_out = '0; bit_length = '0; device_count = '0;
    repeat (3) @(negedge clk);
    chk(bits_align == '0, "reset_bits", bits_align[63:0], 64'd0);
    chk({align_busy, align_done, len_ovf} == 3'b000, "reset_flags", 64'({align_busy, align_done, len_ovf}), 64'd0);
    chk(total_bits == '0, "reset_total", 64'(total_bits), 64'd0);
    rst_n = 1'b1;

    // T1: 8 x 2 = 16 valid bits at the top of the capture.
    cap = '0; cap[DW-1 -: 16] = 16'hA5C3;
    exp = '0; exp[15:0] = 16'hA5C3;
    start_run(cap, 8, 2); wait_done(lat); align = 1'b0;
    chk(lat == 513, "t1_latency", 64'(lat), 64'd513);
    chk(bits_align == exp, "t1_bits", bits_align[63:0], exp[63:0]);
    chk(total_bits == 13'd16, "t1_total", 64'(total_bits), 64'd16);

    // T2: 255 x 31 = 7905 overflows; capture left untouched.
    cap = rand_cap();
    start_run(cap, 255, 31); wait_done(lat); align = 1'b0;
    chk(lat == 3, "t2_latency", 64'(lat), 64'd3);
    chk(len_ovf == 1'b1, "t2_ovf", 64'(len_ovf), 64'd1);
    chk(bits_align == cap, "t2_bits", bits_align[63:0], cap[63:0]);
    chk(total_bits == 13'd7905, "t2_total", 64'(total_bits), 64'd7905);

    // T3: 141 x 29 = 4089, one partial shift of 7; 195 x 21 = 4095, shift of 1.
    cap = rand_cap(); exp = cap >> 7;
    start_run(cap, 141, 29); wait_done(lat); align = 1'b0;
    chk(lat == 4, "t3_latency", 64'(lat), 64'd4);
    chk(bits_align == exp, "t3_bits", bits_align[63:0], exp[63:0]);
    chk(len_ovf == 1'b0, "t3_ovf_cleared", 64'(len_ovf), 64'd0);
    cap = rand_cap(); exp = cap >> 1;
    start_run(cap, 195, 21); wait_done(lat); align = 1'b0;
    chk(lat == 4, "t3b_latency", 64'(lat), 64'd4);
    chk(bits_align == exp, "t3b_bits", bits_align[63:0], exp[63:0]);

    // T4: new align edge with other inputs during SHIFT is dropped.
    cap = rand_cap(); exp = cap >> (DW - 40);
    start_run(cap, 20, 2);
    repeat (50) @(negedge clk);
    align = 1'b0;
    @(negedge clk);
    align = 1'b1; bit_length = 8'd100; JTAG_data_out = rand_cap();
    wait_done(lat);
    chk(bits_align == exp, "t4_bits", bits_align[63:0], exp[63:0]);
    chk(total_bits == 13'd40, "t4_total", 64'(total_bits), 64'd40);
    repeat (20) @(negedge clk);
    chk(align_busy == 1'b0, "t4_level_no_restart", 64'(align_busy), 64'd0);
    align = 1'b0;

    // T5: reset pulse midway through SHIFT, then a fresh run.
    start_run(rand_cap(), 10, 3);
    repeat (100) @(negedge clk);
    align = 1'b0; rst_n = 1'b0;
    #1;
    chk(bits_align == '0, "t5_async_bits", bits_align[63:0], 64'd0);
    chk(align_busy == 1'b0, "t5_async_busy", 64'(align_busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cap = rand_cap(); exp = cap >> (DW - 30);
    start_run(cap, 10, 3); wait_done(lat); align = 1'b0;
    chk(lat == 3 + (DW - 30 + 7) / 8, "t5_latency", 64'(lat), 64'(3 + (DW - 30 + 7) / 8));
    chk(bits_align == exp, "t5_bits", bits_align[63:0], exp[63:0]);

    // T6: zero devices / zero length give an all-zero result.
    start_run(rand_cap(), 37, 0); wait_done(lat); align = 1'b0;
    chk(lat == 515, "t6_latency", 64'(lat), 64'd515);
    chk(bits_align == '0, "t6_bits", bits_align[63:0], 64'd0);
    chk(len_ovf == 1'b0, "t6_ovf", 64'(len_ovf), 64'd0);
    start_run(rand_cap(), 0, 9); wait_done(lat); align = 1'b0;
    chk(bits_align == '0, "t6b_bits", bits_align[63:0], 64'd0);

    // Start while in DONE: a pulsed start, then a new edge on the done cycle.
    cap = rand_cap();
    start_run(cap, 255, 20);
    @(negedge clk); align = 1'b0;
    wait_done(lat);
    cap = rand_cap(); exp = cap >> (DW - 4080);
    JTAG_data_out = cap; bit_length = 8'd255; device_count = 5'd16; align = 1'b1;
    wait_done(lat); align = 1'b0;
    chk(lat == 5, "done_restart_latency", 64'(lat), 64'd5);
    chk(bits_align == exp, "done_restart_bits", bits_align[63:0], exp[63:0]);

    // Random sweep, checked cycle by cycle by the model.
    for (int r = 0; r < 6; r++) begin
      start_run(rand_cap(), int'($urandom_range(255, 0)), int'($urandom_range(31, 0)));
      wait_done(lat);
      align = 1'b0;
    end
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
